chrono_counter: RTL

Time-keeping core of the stopwatch. It sits downstream of the button edge detectors and the clock divider, and upstream of the display multiplexer.
- Consumes one-cycle start/stop/split pulses and a 1 ms tick enable.
- Runs a BCD hh:mm:ss.cc counter under a run/split/stop state machine.
- Presents eight registered BCD digits, either live or frozen at the last split, for the display.

---
 rtl/chrono_pkg.sv | 20 ++
 rtl/bcd_digit_counter.sv | 41 ++++
 rtl/chrono_counter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/chrono_pkg.sv
// Shared definitions for the stopwatch time-keeping core.
// Holds the FSM state encodings, the BCD digit width and the per-digit
// count limits used by the centisecond/second/minute chain.
package chrono_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_SPLIT   = 2'd2,
    ST_STOPPED = 2'd3
  } chrono_state_t;

  localparam int BCD_W = 4;

  // Units digits count 0-9, seconds/minutes tens 0-5, centisecond tens 0-9.
  localparam logic [BCD_W-1:0] UNITS_MAX     = 4'd9;
  localparam logic [BCD_W-1:0] SEXA_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] CENT_TENS_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the stopwatch carry chain.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   clr         - synchronous clear to 0 (wins over inc)
//   inc         - advance by one; wraps to 0 after MAX_VAL
//   val         - current digit value
//   carry_out   - inc while at MAX_VAL (feeds the next digit's inc)
module bcd_digit_counter
  import chrono_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX_VAL = UNITS_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] val,
  output logic             carry_out
);

  logic [BCD_W-1:0] val_r;

  // Digit register; >= keeps the digit in range even if it was ever disturbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_r <= 4'd0;
    end else if (clr) begin
      val_r <= 4'd0;
    end else if (inc) begin
      if (val_r >= MAX_VAL) begin
        val_r <= 4'd0;
      end else begin
        val_r <= val_r + 4'd1;
      end
    end
  end

  assign val       = val_r;
  assign carry_out = inc && (val_r >= MAX_VAL);

endmodule

// File: rtl/chrono_counter.sv
// Stopwatch time-keeping core: BCD hh:mm:ss.cc counter under a
// run/split/stop state machine with registered display digits.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   tick_ms             - 1 ms enable; TICK_DIV of them make one centisecond
//   start_p/stop_p/split_p - one-cycle button pulses (stop > split > start)
//   cent_*/sec_*/min_*/hr_* - registered BCD digits (_0 units, _1 tens);
//                          show the split snapshot while in SPLIT
//   state, running      - registered FSM state and RUNNING|SPLIT flag
//   ovf                 - overflow flag
// Optional build macro CHRONO_OVF_STOP_EN: saturate at HR_MAX:59:59.99,
// raise ovf and force STOPPED instead of wrapping to zero.
module chrono_counter
  import chrono_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int HR_MAX   = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       split_p,
  output logic [3:0] cent_0,
  output logic [3:0] cent_1,
  output logic [3:0] sec_0,
  output logic [3:0] sec_1,
  output logic [3:0] min_0,
  output logic [3:0] min_1,
  output logic [3:0] hr_0,
  output logic [3:0] hr_1,
  output logic [1:0] state,
  output logic       running,
  output logic       ovf
);

  localparam int               PW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST   = PW'(TICK_DIV - 1);
  localparam logic [BCD_W-1:0] HR_TENS_MAX  = BCD_W'(HR_MAX / 10);
  localparam logic [BCD_W-1:0] HR_UNITS_MAX = BCD_W'(HR_MAX % 10);
  localparam int               DIG_BITS     = 8 * BCD_W;

  chrono_state_t             state_r, fsm_next_s, next_state_s;
  logic [PW-1:0]             presc_r;
  logic [7:0][BCD_W-1:0]     live_s, snap_r, disp_r;
  logic [7:0]                carry_s;
  logic                      running_r;
  logic                      counting_s, inc_s, at_max_s, cnt_inc_s, cnt_clr_s;
  logic                      clr_req_s, snap_cap_s, ovf_trip_s, wrap_clr_s, ovf_s;

  assign counting_s = (state_r == ST_RUNNING) || (state_r == ST_SPLIT);
  assign inc_s      = counting_s && tick_ms && (presc_r == PRESC_LAST);

  // Hours are not a pure per-digit limit, so the full-scale point is decoded here.
  assign at_max_s = (live_s[0] == UNITS_MAX) && (live_s[1] == CENT_TENS_MAX) &&
                    (live_s[2] == UNITS_MAX) && (live_s[3] == SEXA_TENS_MAX) &&
                    (live_s[4] == UNITS_MAX) && (live_s[5] == SEXA_TENS_MAX) &&
                    (live_s[6] == HR_UNITS_MAX) && (live_s[7] == HR_TENS_MAX);

`ifdef CHRONO_OVF_STOP_EN
  logic ovf_r;

  assign ovf_trip_s = inc_s && at_max_s;
  assign wrap_clr_s = 1'b0;

  // Overflow flag: set on saturation, cleared only by reset or the clear to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (clr_req_s) begin
      ovf_r <= 1'b0;
    end else if (ovf_trip_s || carry_s[7]) begin
      ovf_r <= 1'b1;
    end
  end

  assign ovf_s = ovf_r;
`else
  // A carry out of the hour tens digit can only mean full scale as well.
  assign ovf_trip_s = 1'b0;
  assign wrap_clr_s = (inc_s && at_max_s) || carry_s[7];
  assign ovf_s      = 1'b0;
`endif

  // Saturation suppresses the increment so the chain holds at full scale.
  assign cnt_inc_s = inc_s && !ovf_trip_s;
  assign cnt_clr_s = clr_req_s || wrap_clr_s;

  bcd_digit_counter #(.MAX_VAL(UNITS_MAX)) u_cent0 (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .inc(cnt_inc_s),  .val(live_s[0]), .carry_out(carry_s[0]));
  bcd_digit_counter #(.MAX_VAL(CENT_TENS_MAX)) u_cent1 (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .inc(carry_s[0]), .val(live_s[1]), .carry_out(carry_s[1]));
  bcd_digit_counter #(.MAX_VAL(UNITS_MAX)) u_sec0 (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .inc(carry_s[1]), .val(live_s[2]), .carry_out(carry_s[2]));
  bcd_digit_counter #(.MAX_VAL(SEXA_TENS_MAX)) u_sec1 (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .inc(carry_s[2]), .val(live_s[3]), .carry_out(carry_s[3]));
  bcd_digit_counter #(.MAX_VAL(UNITS_MAX)) u_min0 (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .inc(carry_s[3]), .val(live_s[4]), .carry_out(carry_s[4]));
  bcd_digit_counter #(.MAX_VAL(SEXA_TENS_MAX)) u_min1 (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .inc(carry_s[4]), .val(live_s[5]), .carry_out(carry_s[5]));
  bcd_digit_counter #(.MAX_VAL(UNITS_MAX)) u_hr0 (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .inc(carry_s[5]), .val(live_s[6]), .carry_out(carry_s[6]));
  bcd_digit_counter #(.MAX_VAL(HR_TENS_MAX)) u_hr1 (
    .clk(clk), .rst(rst), .clr(cnt_clr_s), .inc(carry_s[6]), .val(live_s[7]), .carry_out(carry_s[7]));

  // Next-state decode: only the highest-priority pulse legal in the state acts.
  always_comb begin
    fsm_next_s = state_r;
    clr_req_s  = 1'b0;
    snap_cap_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_p) begin
          fsm_next_s = ST_RUNNING;
          clr_req_s  = 1'b1;
        end else begin
          fsm_next_s = ST_IDLE;
        end
      end
      ST_RUNNING: begin
        if (stop_p) begin
          fsm_next_s = ST_STOPPED;
        end else if (split_p) begin
          fsm_next_s = ST_SPLIT;
          snap_cap_s = 1'b1;
        end else begin
          fsm_next_s = ST_RUNNING;
        end
      end
      ST_SPLIT: begin
        if (stop_p) begin
          fsm_next_s = ST_STOPPED;
        end else if (split_p) begin
          fsm_next_s = ST_RUNNING;
        end else begin
          fsm_next_s = ST_SPLIT;
        end
      end
      ST_STOPPED: begin
        if (split_p) begin
          fsm_next_s = ST_IDLE;
          clr_req_s  = 1'b1;
        end else if (start_p && !ovf_s) begin
          fsm_next_s = ST_RUNNING;
        end else begin
          fsm_next_s = ST_STOPPED;
        end
      end
      default: begin
        fsm_next_s = ST_IDLE;
      end
    endcase
  end

  assign next_state_s = ovf_trip_s ? ST_STOPPED : fsm_next_s;

  // State and running flag move together at the FSM edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      running_r <= (next_state_s == ST_RUNNING) || (next_state_s == ST_SPLIT);
    end
  end

  // Prescaler: divides tick_ms down to centiseconds; held while not counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
    end else if (clr_req_s) begin
      presc_r <= {PW{1'b0}};
    end else if (counting_s && tick_ms) begin
      if (presc_r == PRESC_LAST) begin
        presc_r <= {PW{1'b0}};
      end else begin
        presc_r <= presc_r + PW'(1'b1);
      end
    end
  end

  // Split snapshot: captures the pre-increment live value of the split cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_r <= {DIG_BITS{1'b0}};
    end else if (clr_req_s) begin
      snap_r <= {DIG_BITS{1'b0}};
    end else if (snap_cap_s) begin
      snap_r <= live_s;
    end
  end

  // Display register: uses the current state, so it trails the FSM by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r <= {DIG_BITS{1'b0}};
    end else if (state_r == ST_SPLIT) begin
      disp_r <= snap_r;
    end else begin
      disp_r <= live_s;
    end
  end

  assign cent_0  = disp_r[0];
  assign cent_1  = disp_r[1];
  assign sec_0   = disp_r[2];
  assign sec_1   = disp_r[3];
  assign min_0   = disp_r[4];
  assign min_1   = disp_r[5];
  assign hr_0    = disp_r[6];
  assign hr_1    = disp_r[7];
  assign state   = state_r;
  assign running = running_r;
  assign ovf     = ovf_s;

endmodule
